// File: rtl/load_store_unit.sv
// Load/store sequencer for a word-wide data memory: byte/half/word access,
// read-modify-write for sub-word stores, sign/zero-extended load results.
module load_store_unit #(
    parameter int MEM_WORDS = 128
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mwr,
    output logic        moe,
    output logic [31:0] ma,
    output logic [31:0] mwd,
    input  logic [31:0] mrd
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD     = 3'd1;
    localparam logic [2:0] RMW_READ = 3'd2;
    localparam logic [2:0] WRITE    = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

    logic [2:0]  state_q, state_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] merged_q, merged_d;

    logic        accept;
    logic        req_bad;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;

    assign accept = req_valid && (state_q == IDLE);

    assign req_bad = (req_size == 2'b11)
                  || ((req_size == SZ_HALF) && req_addr[0])
                  || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                  || (req_addr[31:2] >= MEM_WORDS_W);

    assign byte_lane = mrd[{addr_q[1:0], 3'b000} +: 8];
    assign half_lane = mrd[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_data = mrd;
        merged_d  = mrd;
        case (size_q)
            SZ_BYTE: begin
                load_data = {{24{signed_q & byte_lane[7]}}, byte_lane};
                merged_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{signed_q & half_lane[15]}}, half_lane};
                merged_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rdata_d = 32'd0;
                    err_d   = req_bad;
                    if (req_bad)                   state_d = RESP;
                    else if (!req_we)              state_d = LOAD;
                    else if (req_size == SZ_WORD)  state_d = WRITE;
                    else                           state_d = RMW_READ;
                end
            end
            LOAD: begin
                rdata_d = load_data;
                state_d = RESP;
            end
            RMW_READ: state_d = WRITE;
            WRITE:    state_d = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            merged_q <= 32'd0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q     <= req_we;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (state_q == RMW_READ) begin
                merged_q <= merged_d;
            end
        end
    end

    // Memory port is a pure decode of registered state, so it holds for the whole cycle.
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
        moe        = (state_q == LOAD) || (state_q == RMW_READ);
        mwr        = (state_q == WRITE) && we_q;
        ma         = 32'd0;
        mwd        = 32'd0;
        if (moe || mwr) begin
            ma = {2'b00, addr_q[31:2]};
        end
        if (mwr) begin
            mwd = (size_q == SZ_WORD) ? wdata_q : merged_q;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 128-word memory.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mwr, moe;
    logic [31:0] ma, mwd, mrd;

    logic [31:0] mem [0:127];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    load_store_unit #(.MEM_WORDS(128)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mwr(mwr), .moe(moe), .ma(ma), .mwd(mwd), .mrd(mrd)
    );

    assign mrd = moe ? mem[ma[6:0]] : 32'd0;
    always @(posedge clock) if (mwr) mem[ma[6:0]] <= mwd;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          n_moe;
        int          n_mwr;
        int          midx;
        logic [31:0] mval;
    } vec_t;

    vec_t vecs [0:19];
    int   nvec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc = 0;
        int nm = 0;
        int nw = 0;
        int both = 0;
        logic [31:0] wr_ma = 32'hFFFF_FFFF;
        @(negedge clock);
        check({v.name, " req_ready"}, {31'd0, req_ready}, 32'd1);
        req_we = v.we; req_size = v.size; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        resp_ready = 1'b0;
        @(posedge clock);
        #1 req_valid = 1'b0;
        while (cyc < 10) begin
            @(negedge clock);
            cyc++;
            if (moe) nm++;
            if (mwr) begin nw++; wr_ma = ma; end
            if (moe && mwr) both++;
            if (resp_valid) break;
        end
        check({v.name, " latency"}, 32'(cyc), 32'(v.lat));
        check({v.name, " rdata"}, resp_rdata, v.rdata);
        check({v.name, " err"}, {31'd0, resp_err}, {31'd0, v.err});
        check({v.name, " moe cycles"}, 32'(nm), 32'(v.n_moe));
        check({v.name, " mwr cycles"}, 32'(nw), 32'(v.n_mwr));
        check({v.name, " mwr&moe"}, 32'(both), 32'd0);
        if (v.n_mwr > 0) check({v.name, " write ma"}, wr_ma, {2'b00, v.addr[31:2]});
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        check({v.name, " mem"}, mem[v.midx], v.mval);
        $display("txn %-14s we=%0b size=%0d addr=0x%08h rdata=0x%08h err=%0b lat=%0d",
                 v.name, v.we, v.size, v.addr, resp_rdata, resp_err, cyc);
    endtask

    initial begin
        logic [31:0] held;
        int cyc;
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;

        //            name            we  size  sg  addr          wdata          rdata         err lat moe mwr idx mval
        vecs[0]  = '{"st_w 0x10",     1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 4,  32'hDEADBEEF};
        vecs[1]  = '{"ld_w 0x10",     0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 4,  32'hDEADBEEF};
        vecs[2]  = '{"st_w init",     1, 2'b10, 0, 32'h10,  32'h11223344, 32'h0,        0, 2, 0, 1, 4,  32'h11223344};
        vecs[3]  = '{"st_b 0x12",     1, 2'b00, 0, 32'h12,  32'h000000AA, 32'h0,        0, 3, 1, 1, 4,  32'h11AA3344};
        vecs[4]  = '{"ld_bs 0x12",    0, 2'b00, 1, 32'h12,  32'h0,        32'hFFFFFFAA, 0, 2, 1, 0, 4,  32'h11AA3344};
        vecs[5]  = '{"ld_bu 0x12",    0, 2'b00, 0, 32'h12,  32'h0,        32'h000000AA, 0, 2, 1, 0, 4,  32'h11AA3344};
        vecs[6]  = '{"st_b 0x13",     1, 2'b00, 1, 32'h13,  32'hFFFFFF55, 32'h0,        0, 3, 1, 1, 4,  32'h55AA3344};
        vecs[7]  = '{"ld_bs 0x13",    0, 2'b00, 1, 32'h13,  32'h0,        32'h00000055, 0, 2, 1, 0, 4,  32'h55AA3344};
        vecs[8]  = '{"st_h 0x16",     1, 2'b01, 0, 32'h16,  32'h00008001, 32'h0,        0, 3, 1, 1, 5,  32'h80010000};
        vecs[9]  = '{"ld_hs 0x16",    0, 2'b01, 1, 32'h16,  32'h0,        32'hFFFF8001, 0, 2, 1, 0, 5,  32'h80010000};
        vecs[10] = '{"ld_hu 0x16",    0, 2'b01, 0, 32'h16,  32'h0,        32'h00008001, 0, 2, 1, 0, 5,  32'h80010000};
        vecs[11] = '{"ld_hs 0x10",    0, 2'b01, 1, 32'h10,  32'h0,        32'h00003344, 0, 2, 1, 0, 4,  32'h55AA3344};
        vecs[12] = '{"err ld_w 0x11", 0, 2'b10, 0, 32'h11,  32'h0,        32'h0,        1, 1, 0, 0, 4,  32'h55AA3344};
        vecs[13] = '{"err ld_h 0x13", 0, 2'b01, 1, 32'h13,  32'h0,        32'h0,        1, 1, 0, 0, 4,  32'h55AA3344};
        vecs[14] = '{"err size 11",   1, 2'b11, 0, 32'h10,  32'h12345678, 32'h0,        1, 1, 0, 0, 4,  32'h55AA3344};
        vecs[15] = '{"err ld 0x200",  0, 2'b10, 0, 32'h200, 32'h0,        32'h0,        1, 1, 0, 0, 4,  32'h55AA3344};
        vecs[16] = '{"err st_w 0x12", 1, 2'b10, 0, 32'h12,  32'h0,        32'h0,        1, 1, 0, 0, 4,  32'h55AA3344};
        vecs[17] = '{"st_w 0x1FC",    1, 2'b10, 0, 32'h1FC, 32'hCAFEF00D, 32'h0,        0, 2, 0, 1, 127, 32'hCAFEF00D};
        vecs[18] = '{"ld_w 0x1FC",    0, 2'b10, 0, 32'h1FC, 32'h0,        32'hCAFEF00D, 0, 2, 1, 0, 127, 32'hCAFEF00D};
        nvec = 19;

        // Reset values while reset is held, before any clock edge
        #2;
        check("rst req_ready",  {31'd0, req_ready},  32'd1);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst resp_rdata", resp_rdata,          32'd0);
        check("rst resp_err",   {31'd0, resp_err},   32'd0);
        check("rst mwr/moe",    {30'd0, mwr, moe},   32'd0);
        check("rst ma",         ma,                  32'd0);
        check("rst mwd",        mwd,                 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < nvec; i++) run_vec(vecs[i]);

        // Backpressure on a load, with a second request waiting
        mem[8] = 32'h0BADC0DE;
        @(negedge clock);
        req_we = 0; req_size = 2'b10; req_signed = 0; req_addr = 32'h20; req_valid = 1;
        @(posedge clock);
        #1;
        req_size = 2'b00; req_addr = 32'h12;
        cyc = 0;
        do begin @(negedge clock); cyc++; end while (!resp_valid && cyc < 10);
        check("bp latency", 32'(cyc), 32'd2);
        held = resp_rdata;
        check("bp rdata", held, 32'h0BADC0DE);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("bp resp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp rdata hold", resp_rdata, held);
            check("bp req_ready",  {31'd0, req_ready},  32'd0);
            check("bp no access",  {30'd0, mwr, moe},   32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        @(negedge clock);
        check("bp idle req_ready",  {31'd0, req_ready},  32'd1);
        check("bp idle resp_valid", {31'd0, resp_valid}, 32'd0);
        check("bp idle moe",        {31'd0, moe},        32'd0);
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("bp 2nd moe", {31'd0, moe}, 32'd1);
        check("bp 2nd ma",  ma,           32'd4);
        @(negedge clock);
        check("bp 2nd valid", {31'd0, resp_valid}, 32'd1);
        check("bp 2nd rdata", resp_rdata,          32'h000000AA);
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        $display("txn backpressure  load 0x20 held 5 cycles, pending byte load 0x12 accepted after handshake");

        // Asynchronous reset during WRITE drops the store
        mem[9] = 32'h12345678;
        @(negedge clock);
        req_we = 1; req_size = 2'b10; req_addr = 32'h24; req_wdata = 32'hFFFFFFFF; req_valid = 1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("rst-mid mwr before", {31'd0, mwr}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst-mid mwr",        {31'd0, mwr},        32'd0);
        check("rst-mid moe",        {31'd0, moe},        32'd0);
        check("rst-mid ma",         ma,                  32'd0);
        check("rst-mid mwd",        mwd,                 32'd0);
        check("rst-mid req_ready",  {31'd0, req_ready},  32'd1);
        check("rst-mid resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        check("rst-mid mem kept", mem[9], 32'h12345678);
        $display("txn reset in WRITE store 0x24 dropped");
        run_vec('{"ld_w after rst", 0, 2'b10, 0, 32'h24, 32'h0, 32'h12345678, 0, 2, 1, 0, 9, 32'h12345678});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store sequencer between the execute stage and the word-wide data memory. Accepts one byte/halfword/word load or store per transaction over a valid/ready handshake, converts byte addresses to word indices, performs read-modify-write for sub-word stores, and returns sign- or zero-extended load data over a valid/ready response channel. It is the only master on the memory's `mwr`/`moe`/`ma`/`mwd`/`mrd` port.

## Interface
- `MEM_WORDS`, 128: number of 32-bit words in data memory; word indices `>= MEM_WORDS` are out of range.
- `clock` input 1: sole clock; all state changes on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request.
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 half, 10 word; 11 is illegal.
- `req_signed` input 1: sign-extend load data (ignored for word loads and stores).
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `resp_valid` output 1: response present.
- `resp_ready` input 1: consumer takes the response.
- `resp_rdata` output 32: load result; 0 for stores and errors.
- `resp_err` output 1: misaligned, illegal size, or out-of-range request.
- `mwr` output 1: memory write enable.
- `moe` output 1: memory output enable.
- `ma` output 32: memory word index, `{2'b00, addr[31:2]}`.
- `mwd` output 32: memory write data.
- `mrd` input 32: memory read data, combinational from `ma` when `moe`=1.

## Operation
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- IDLE: `req_ready`=1 (combinational on state only, never on `req_valid`). Handshake on `req_valid & req_ready` at a rising edge latches `req_*` into internal registers. Next state:
  - error (size 11; half with addr[0]=1; word with addr[1:0]≠0; addr[31:2] ≥ MEM_WORDS) → RESP with `resp_err`=1, no memory access.
  - load → LOAD.
  - word store → WRITE.
  - byte/half store → RMW_READ.
- LOAD: `moe`=1, `ma`=word index. At the edge, extract the lane from `mrd` and register it into `resp_rdata` → RESP.
- RMW_READ: `moe`=1, `ma`=word index. At the edge, register the merged word: `mrd` with the addressed byte lane (8*addr[1:0]) or half lane (16*addr[1]) replaced by `req_wdata[7:0]`/`[15:0]` → WRITE.
- WRITE: `mwr`=1, `moe`=0, `ma`=word index, `mwd`=merged word (sub-word) or `req_wdata` (word). Memory captures at the edge → RESP with `resp_rdata`=0.
- RESP: `resp_valid`=1. `resp_rdata`/`resp_err` are held stable until `resp_valid & resp_ready` at an edge → IDLE. No new request is accepted in RESP.
- Little-endian lanes. Byte load: `mrd[8*off+:8]`. Half load: `mrd[16*addr[1]+:16]`. Each is zero- or sign-extended per `req_signed`.
- Outside LOAD/RMW_READ/WRITE: `mwr`=0, `moe`=0, `ma`=0, `mwd`=0. `mwr` and `moe` are never both 1.

## Timing
- Reset (async assert): state IDLE. `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mwr`=0, `moe`=0, `ma`=0, `mwd`=0, all taking effect immediately without a clock.
- Reset mid-transaction: the transaction is dropped with no response. `mwr` falls with `reset_n`. A write already committed at a prior edge stands. In RMW_READ no write occurs.
- Latency from accept edge E0 to `resp_valid` high:
  - error: after E0 (1 cycle).
  - load / word store: after E1 (2 cycles).
  - sub-word store: after E2 (3 cycles).
- Back-to-back throughput: with `resp_ready` held at 1, the next request is accepted at the edge after the RESP cycle. Word load/store takes 3 cycles per transaction.
- Memory outputs are registered-state-decoded, glitch-free, and stable for the entire state cycle.

## Test plan
- Word store then load: store addr 0x10, data 0xDEADBEEF. `mwr`=1 with `ma`=4 for exactly one cycle. A following word load at 0x10 returns 0xDEADBEEF, `resp_err`=0, with `resp_valid` 2 cycles after accept.
- Byte RMW: memory word 4 = 0x11223344. Byte store 0xAA at addr 0x12 yields memory 0x11AA3344, with one `moe` cycle followed by one `mwr` cycle. Signed byte load at 0x12 returns 0xFFFFFFAA; unsigned returns 0x000000AA.
- Half lanes: half store 0x8001 at addr 0x16 into 0x00000000 yields 0x80010000. Signed half load returns 0xFFFF8001.
- Errors: word load at 0x11, half load at 0x13, size 11, and word load at addr 0x200 (index 128) each give `resp_err`=1 and `resp_rdata`=0 one cycle after accept, with `mwr`/`moe` never asserted.
- Backpressure: hold `resp_ready`=0 for 5 cycles after a load. `resp_valid` and `resp_rdata` stay stable, `req_ready`=0, and a pending `req_valid` is not accepted until the cycle after the response handshake.
- Reset: assert `reset_n`=0 during WRITE. `mwr` drops asynchronously and all outputs go to reset values. After release, IDLE accepts a new request normally.
